// File: rtl/gelato_fetch_scheduler_pkg.sv
// Shared types and default sizing for the warp fetch scheduler.
// Bit widths here describe the default configuration; the RTL modules
// derive their own widths from their parameters.
package gelato_fetch_scheduler_pkg;

    localparam int GFS_WARP_NUM = 4;
    localparam int GFS_PC_WIDTH = 32;
    localparam int GFS_SPLIT_W  = 5;

    typedef logic [$clog2(GFS_WARP_NUM)-1:0] warp_num_t;
    typedef logic [GFS_PC_WIDTH-1:0]         pc_t;
    typedef logic [GFS_SPLIT_W-1:0]          split_table_num_t;

    // One fetch request as seen by the instruction fetch stage.
    typedef struct packed {
        warp_num_t        warp;
        pc_t              pc;
        split_table_num_t split_num;
    } fetch_req_t;

endpackage

// File: rtl/gelato_fetch_scheduler_if.sv
// Valid/ready fetch request channel from the scheduler to instruction fetch.
interface gelato_fetch_scheduler_if
    import gelato_fetch_scheduler_pkg::*;
#(
    parameter int WARP_NUM = GFS_WARP_NUM,
    parameter int PC_WIDTH = GFS_PC_WIDTH,
    parameter int SPLIT_W  = GFS_SPLIT_W
);
    logic                        fetch_valid;
    logic                        fetch_ready;
    logic [$clog2(WARP_NUM)-1:0] fetch_warp;
    logic [PC_WIDTH-1:0]         fetch_pc;
    logic [SPLIT_W-1:0]          fetch_split_num;

    modport master (
        output fetch_valid,
        output fetch_warp,
        output fetch_pc,
        output fetch_split_num,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_warp,
        input  fetch_pc,
        input  fetch_split_num,
        output fetch_ready
    );
endinterface

// File: rtl/gelato_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and
// wraps, so the requester granted last time gets lowest priority next.
module gelato_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    // Walk the N candidates in priority order and keep the first requester.
    always_comb begin
        logic [IW-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            // N is a power of two, so truncation to IW bits is the modulo.
            cand = ptr + IW'(k);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Warp fetch scheduler: picks one eligible warp per cycle round-robin and
// holds it in an output register toward the fetch stage. A warp is blocked
// after issue until decode/split re-activates it.
module gelato_fetch_scheduler
    import gelato_fetch_scheduler_pkg::*;
#(
    parameter int WARP_NUM = GFS_WARP_NUM,
    parameter int PC_WIDTH = GFS_PC_WIDTH,
    parameter int SPLIT_W  = GFS_SPLIT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic [WARP_NUM-1:0]          pc_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0] pc,
    input  logic [WARP_NUM*SPLIT_W-1:0]  split_num,
    input  logic                         activate_valid,
    input  logic [$clog2(WARP_NUM)-1:0]  activate_warp,
    gelato_fetch_scheduler_if.master     fetch,
    output logic [31:0]                  issue_count
);
    localparam int WW = $clog2(WARP_NUM);

    logic [WARP_NUM-1:0] inflight;
    logic [WARP_NUM-1:0] inflight_next;
    logic [WARP_NUM-1:0] clr_mask;
    logic [WARP_NUM-1:0] elig;
    logic [WARP_NUM-1:0] grant;
    logic [WW-1:0]       rr_ptr;
    logic [WW-1:0]       win_idx;
    logic                any_elig;
    logic                free;
    logic                load;
    logic                xfer;

    assign elig = pc_valid & ~inflight;
    assign free = ~fetch.fetch_valid | fetch.fetch_ready;
    assign load = free & any_elig;
    assign xfer = fetch.fetch_valid & fetch.fetch_ready;

    gelato_rr_arbiter #(
        .N (WARP_NUM)
    ) u_arb (
        .req       (elig),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .any       (any_elig)
    );

    // Inflight update: re-activation clears first, then a new issue sets,
    // so an issue-set wins over a clear of the same warp.
    always_comb begin
        clr_mask = '0;
        if (activate_valid) begin
            clr_mask[activate_warp] = 1'b1;
        end
        inflight_next = inflight & ~clr_mask;
        if (load) begin
            inflight_next = inflight_next | grant;
        end
    end

    // Scheduling state and output register; rdy low freezes everything,
    // flush clears scheduling state but keeps the issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight              <= '0;
            rr_ptr                <= WW'(WARP_NUM - 1);
            fetch.fetch_valid     <= 1'b0;
            fetch.fetch_warp      <= '0;
            fetch.fetch_pc        <= '0;
            fetch.fetch_split_num <= '0;
            issue_count           <= '0;
        end else if (rdy) begin
            if (flush) begin
                inflight          <= '0;
                rr_ptr            <= WW'(WARP_NUM - 1);
                fetch.fetch_valid <= 1'b0;
            end else begin
                inflight <= inflight_next;
                if (xfer) begin
                    issue_count <= issue_count + 32'd1;
                end
                if (free) begin
                    fetch.fetch_valid <= any_elig;
                end
                if (load) begin
                    rr_ptr                <= win_idx;
                    fetch.fetch_warp      <= win_idx;
                    fetch.fetch_pc        <= pc[win_idx*PC_WIDTH +: PC_WIDTH];
                    fetch.fetch_split_num <= split_num[win_idx*SPLIT_W +: SPLIT_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Directed bench for the warp fetch scheduler with a transfer scoreboard.
module tb_gelato_fetch_scheduler;
    import gelato_fetch_scheduler_pkg::*;

    localparam int WN = 4;
    localparam int PW = 32;
    localparam int SW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rdy;
    logic           flush;
    logic [WN-1:0]  pc_valid;
    logic [WN*PW-1:0] pc;
    logic [WN*SW-1:0] split_num;
    logic           activate_valid;
    logic [1:0]     activate_warp;
    logic [31:0]    issue_count;
    logic [PW-1:0]  pc_hold;

    int checks   = 0;
    int failures = 0;
    fetch_req_t sb[$];

    gelato_fetch_scheduler_if #(.WARP_NUM(WN), .PC_WIDTH(PW), .SPLIT_W(SW)) fif ();

    gelato_fetch_scheduler #(
        .WARP_NUM (WN),
        .PC_WIDTH (PW),
        .SPLIT_W  (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .flush          (flush),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .split_num      (split_num),
        .activate_valid (activate_valid),
        .activate_warp  (activate_warp),
        .fetch          (fif.master),
        .issue_count    (issue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic fetch_req_t req_of(input int w);
        fetch_req_t r;
        r.warp      = warp_num_t'(w);
        r.pc        = pc[w*PW +: PW];
        r.split_num = split_num[w*SW +: SW];
        return r;
    endfunction

    task automatic push(input int w);
        sb.push_back(req_of(w));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int w);
        check({tag, "_valid"}, 64'(fif.fetch_valid), 64'd1);
        check({tag, "_warp"}, 64'(fif.fetch_warp), 64'(w));
    endtask

    // Scoreboard: every accepted request must match the oldest expected one.
    always @(negedge clk) begin
        fetch_req_t got;
        fetch_req_t exp;
        if (rst_n === 1'b1 && rdy && fif.fetch_valid && fif.fetch_ready) begin
            got.warp      = fif.fetch_warp;
            got.pc        = fif.fetch_pc;
            got.split_num = fif.fetch_split_num;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=%0h expected=none", got);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("sb_payload", 64'(got), 64'(exp));
            end
        end
    end

    // A clear and an issue-set of the same warp in one cycle is illegal stimulus.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rdy && !flush && activate_valid) begin
            assert (!(dut.load && dut.grant[activate_warp])) else begin
                failures++;
                $error("FAIL act_issue_collision observed=%0d expected=none", activate_warp);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        rdy            = 1'b1;
        flush          = 1'b0;
        pc_valid       = '0;
        activate_valid = 1'b0;
        activate_warp  = '0;
        fif.fetch_ready = 1'b1;
        for (int i = 0; i < WN; i++) begin
            pc[i*PW +: PW]        = 32'h1000_0000 + 32'(i * 'h40);
            split_num[i*SW +: SW] = SW'(i + 3);
        end

        // Reset state
        #12;
        check("rst_valid", 64'(fif.fetch_valid), 64'd0);
        check("rst_warp", 64'(fif.fetch_warp), 64'd0);
        check("rst_pc", 64'(fif.fetch_pc), 64'd0);
        check("rst_split", 64'(fif.fetch_split_num), 64'd0);
        check("rst_count", 64'(issue_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("idle_valid", 64'(fif.fetch_valid), 64'd0);

        // All warps valid: 0,1,2,3 then nothing until re-activation
        pc_valid = 4'b1111;
        for (int i = 0; i < WN; i++) push(i);
        for (int i = 0; i < WN; i++) begin
            tick(1);
            check_grant("t1", i);
        end
        tick(1);
        check("t1_drain_valid", 64'(fif.fetch_valid), 64'd0);
        check("t1_count", 64'(issue_count), 64'd4);
        tick(2);
        check("t1_blocked_valid", 64'(fif.fetch_valid), 64'd0);

        // Only warps 0 and 2 valid, re-activated right after each issue
        pc_valid = 4'b0101;
        push(0); push(2); push(0); push(2);
        activate_valid = 1'b1;
        activate_warp  = 2'd0;
        tick(1);
        check("t2_pre_valid", 64'(fif.fetch_valid), 64'd0);
        activate_warp = 2'd2;
        tick(1);
        check_grant("t2_a", 0);
        activate_warp = 2'd0;
        tick(1);
        check_grant("t2_b", 2);
        activate_warp = 2'd2;
        tick(1);
        check_grant("t2_c", 0);
        activate_valid = 1'b0;
        tick(1);
        check_grant("t2_d", 2);
        tick(1);
        check("t2_drain_valid", 64'(fif.fetch_valid), 64'd0);
        check("t2_count", 64'(issue_count), 64'd8);

        // Backpressure on warp 1: payload held even if its pc inputs change
        pc_valid        = 4'b0010;
        fif.fetch_ready = 1'b0;
        activate_valid  = 1'b1;
        activate_warp   = 2'd1;
        push(1);
        pc_hold = pc[1*PW +: PW];
        tick(1);
        activate_valid = 1'b0;
        check("t3_pre_valid", 64'(fif.fetch_valid), 64'd0);
        tick(1);
        check_grant("t3_load", 1);
        pc_valid = 4'b0000;
        pc[1*PW +: PW] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_grant("t3_hold", 1);
            check("t3_hold_pc", 64'(fif.fetch_pc), 64'(pc_hold));
            check("t3_hold_count", 64'(issue_count), 64'd8);
        end
        fif.fetch_ready = 1'b1;
        tick(1);
        check("t3_rel_valid", 64'(fif.fetch_valid), 64'd0);
        check("t3_rel_count", 64'(issue_count), 64'd9);
        pc[1*PW +: PW] = pc_hold;

        // rdy low freezes the request and ignores re-activation
        fif.fetch_ready = 1'b0;
        pc_valid        = 4'b0001;
        activate_valid  = 1'b1;
        activate_warp   = 2'd0;
        push(0);
        tick(1);
        activate_valid = 1'b0;
        tick(1);
        check_grant("t4_load", 0);
        rdy             = 1'b0;
        activate_valid  = 1'b1;
        activate_warp   = 2'd2;
        fif.fetch_ready = 1'b1;
        pc_valid        = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check_grant("t4_frozen", 0);
            check("t4_frozen_count", 64'(issue_count), 64'd9);
        end
        rdy            = 1'b1;
        activate_valid = 1'b0;
        tick(1);
        check("t4_after_valid", 64'(fif.fetch_valid), 64'd0);
        check("t4_after_count", 64'(issue_count), 64'd10);
        tick(1);
        check("t4_still_blocked", 64'(fif.fetch_valid), 64'd0);

        // Flush with warps 0 and 2 inflight and warp 2 pending
        fif.fetch_ready = 1'b0;
        activate_valid  = 1'b1;
        activate_warp   = 2'd2;
        tick(1);
        activate_valid = 1'b0;
        check("t5_pre_valid", 64'(fif.fetch_valid), 64'd0);
        tick(1);
        check_grant("t5_pending", 2);
        flush = 1'b1;
        tick(1);
        check("t5_flush_valid", 64'(fif.fetch_valid), 64'd0);
        check("t5_flush_count", 64'(issue_count), 64'd10);
        flush           = 1'b0;
        fif.fetch_ready = 1'b1;
        push(0); push(2);
        tick(1);
        check_grant("t5_first", 0);
        tick(1);
        check_grant("t5_second", 2);
        tick(1);
        check("t5_drain_valid", 64'(fif.fetch_valid), 64'd0);
        check("t5_count", 64'(issue_count), 64'd12);

        // Asynchronous reset while a request is pending
        pc_valid        = 4'b0010;
        fif.fetch_ready = 1'b0;
        tick(1);
        check_grant("t6_pending", 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(fif.fetch_valid), 64'd0);
        check("t6_rst_warp", 64'(fif.fetch_warp), 64'd0);
        check("t6_rst_pc", 64'(fif.fetch_pc), 64'd0);
        check("t6_rst_count", 64'(issue_count), 64'd0);
        @(negedge clk);
        rst_n           = 1'b1;
        pc_valid        = 4'b1111;
        fif.fetch_ready = 1'b1;
        for (int i = 0; i < WN; i++) push(i);
        for (int i = 0; i < WN; i++) begin
            tick(1);
            check_grant("t6_post", i);
        end
        tick(1);
        check("t6_drain_valid", 64'(fif.fetch_valid), 64'd0);
        check("t6_count", 64'(issue_count), 64'd4);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the directed sequence is ever left waiting.
    initial begin
        #100000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
